// File: rtl/pp_row_sequencer.sv
// Partial-product row sequencer: accepts one N x N operand pair and emits its
// partial-product rows one per beat (Baugh-Wooley forms plus a correction beat in signed mode).
module pp_row_sequencer #(
    parameter int N         = 16,
    parameter bit SKIP_ZERO = 1'b0,
    localparam int IW       = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_row,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          busy,
    output logic          dbg_state
);

    // Handshake: a transfer happens on a rising clk edge when valid and ready
    // are both high; valid and its payload stay stable until that transfer.

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          sgn_q, sgn_d;
    logic [N-1:0]  row_q, row_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          last_q, last_d;
    logic          valid_q, valid_d;

    // Lowest set bit of b at or above position from; -1 when there is none.
    function automatic int first_set(input logic [N-1:0] b, input int from);
        logic [N-1:0] bs;
        first_set = -1;
        for (int i = N - 1; i >= 0; i--) begin
            bs = b >> i;
            if (i >= from && bs[0]) first_set = i;
        end
    endfunction

    function automatic logic [N-1:0] make_row(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic sgn, input int k);
        logic [N-1:0] r;
        logic [N-1:0] bs;
        logic         bk;
        bs = b >> k;
        bk = (k < N) ? bs[0] : 1'b0;
        r  = '0;
        if (!sgn) begin
            r = a & {N{bk}};
        end else if (k == N) begin
            r[0]   = 1'b1;
            r[N-1] = 1'b1;
        end else if (k == N - 1) begin
            r      = ~(a & {N{bk}});
            r[N-1] = a[N-1] & bk;
        end else begin
            r      = a & {N{bk}};
            r[N-1] = ~(a[N-1] & bk);
        end
        return r;
    endfunction

    // Operands come straight from the ports in IDLE so the first beat can be
    // registered on the accepting edge.
    logic [N-1:0] src_a, src_b;
    logic         src_sgn, src_skip;
    int           k, fs, fs_next;
    logic         last_k;
    logic [N-1:0] row_k;
    logic         accept, fire;

    always_comb begin
        src_a    = (state_q == IDLE) ? in_a : a_q;
        src_b    = (state_q == IDLE) ? in_b : b_q;
        src_sgn  = (state_q == IDLE) ? in_signed : sgn_q;
        src_skip = SKIP_ZERO && !src_sgn;

        if (state_q == IDLE) fs = first_set(src_b, 0);
        else                 fs = first_set(src_b, int'(idx_q) + 1);

        if (state_q == IDLE) k = (src_skip && fs >= 0) ? fs : 0;
        else                 k = src_skip ? ((fs >= 0) ? fs : 0) : int'(idx_q) + 1;

        fs_next = first_set(src_b, k + 1);
        if (src_sgn)       last_k = (k == N);
        else if (src_skip) last_k = (fs_next < 0);
        else               last_k = (k == N - 1);

        row_k = make_row(src_a, src_b, src_sgn, k);
    end

    assign in_ready = !rst && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign fire     = valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        row_d   = row_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sgn_d   = in_signed;
                    row_d   = row_k;
                    idx_d   = IW'(k);
                    last_d  = last_k;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (fire) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        row_d  = row_k;
                        idx_d  = IW'(k);
                        last_d = last_k;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            row_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign busy      = (state_q == EMIT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pp_row_sequencer.sv
// Directed bench for pp_row_sequencer at N=4, one instance per SKIP_ZERO setting.
module tb_pp_row_sequencer;
  localparam int N  = 4;
  localparam int IW = 3;

  logic clk;
  logic rst;
  logic sel;  // 1 selects the SKIP_ZERO=1 instance
  logic in_valid;
  logic [N-1:0] in_a, in_b;
  logic in_signed;
  logic out_ready;

  logic iv_z, ir_z, ov_z, ol_z, bz_z, st_z;
  logic [N-1:0] or_z;
  logic [IW-1:0] oi_z;
  logic iv_n, ir_n, ov_n, ol_n, bz_n, st_n;
  logic [N-1:0] or_n;
  logic [IW-1:0] oi_n;

  assign iv_z = in_valid & sel;
  assign iv_n = in_valid & !sel;

  pp_row_sequencer #(.N(N), .SKIP_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst), .in_valid(iv_z), .in_ready(ir_z), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov_z), .out_ready(out_ready), .out_row(or_z),
    .out_idx(oi_z), .out_last(ol_z), .busy(bz_z), .dbg_state(st_z)
  );

  pp_row_sequencer #(.N(N), .SKIP_ZERO(1'b0)) dut_n (
    .clk(clk), .rst(rst), .in_valid(iv_n), .in_ready(ir_n), .in_a(in_a), .in_b(in_b),
    .in_signed(in_signed), .out_valid(ov_n), .out_ready(out_ready), .out_row(or_n),
    .out_idx(oi_n), .out_last(ol_n), .busy(bz_n), .dbg_state(st_n)
  );

  logic o_ready, o_valid, o_last, o_busy;
  logic [N-1:0] o_row;
  logic [IW-1:0] o_idx;
  assign o_ready = sel ? ir_z : ir_n;
  assign o_valid = sel ? ov_z : ov_n;
  assign o_last  = sel ? ol_z : ol_n;
  assign o_busy  = sel ? bz_z : bz_n;
  assign o_row   = sel ? or_z : or_n;
  assign o_idx   = sel ? oi_z : oi_n;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Beats as {last, idx, row} bytes, shifted in oldest first.
  logic [39:0] got_vec;
  int got_n;
  logic [7:0] got_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input bit keep);
    int w;
    in_a = a;
    in_b = b;
    in_signed = s;
    in_valid = 1'b1;
    w = 0;
    while (o_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    checks++;
    if (w >= 20) begin
      fails++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", o_ready, w);
    end else passes++;
    step();
    if (!keep) in_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL first_beat_latency: out_valid=%b busy=%b, required 1 1", o_valid, o_busy);
    end else passes++;
  endtask

  // pat 0: always ready; pat 1: ready pattern 1,0,0,1,0,0,...
  task automatic collect(input int pat);
    int cyc;
    bit done, held;
    int bad_busy, bad_ready, bad_stable, bad_valid;
    logic [N-1:0] h_row;
    logic [IW-1:0] h_idx;
    logic h_last;
    cyc = 0; done = 0; held = 0;
    bad_busy = 0; bad_ready = 0; bad_stable = 0; bad_valid = 0;
    got_vec = '0; got_n = 0; got_sum = '0;
    h_row = '0; h_idx = '0; h_last = 1'b0;
    while (!done && cyc < 100) begin
      out_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (o_busy !== 1'b1) bad_busy++;
      if (o_ready !== 1'b0) bad_ready++;
      if (o_valid !== 1'b1) bad_valid++;
      if (held && (o_row !== h_row || o_idx !== h_idx || o_last !== h_last)) bad_stable++;
      if (o_valid === 1'b1 && out_ready) begin
        got_vec = {got_vec[31:0], o_last, o_idx, o_row};
        got_n++;
        got_sum = got_sum + 8'((16'(o_row) << o_idx));
        held = 0;
        if (o_last === 1'b1) done = 1;
      end else begin
        held = 1;
        h_row = o_row; h_idx = o_idx; h_last = o_last;
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL collect_timeout: no last beat within %0d cycles, %0d beats seen", cyc, got_n);
    end else passes++;
    checks++;
    if (bad_busy != 0 || bad_ready != 0 || bad_valid != 0) begin
      fails++;
      $display("FAIL emit_flags: busy_bad=%0d in_ready_bad=%0d valid_bad=%0d, required 0 0 0",
               bad_busy, bad_ready, bad_valid);
    end else passes++;
    checks++;
    if (bad_stable != 0) begin
      fails++;
      $display("FAIL stall_stable: %0d changed beats under stall, required 0", bad_stable);
    end else passes++;
  endtask

  task automatic check_product(input string name, input int exp_n, input logic [39:0] exp_vec,
                               input logic [7:0] exp_sum);
    checks++;
    if (got_n !== exp_n || got_vec !== exp_vec) begin
      fails++;
      $display("FAIL %s_beats: got n=%0d %h, required n=%0d %h", name, got_n, got_vec, exp_n, exp_vec);
    end else passes++;
    checks++;
    if (got_sum !== exp_sum) begin
      fails++;
      $display("FAIL %s_sum: got %0d, required %0d", name, got_sum, exp_sum);
    end else passes++;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_complete: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               name, o_valid, o_busy, o_ready);
    end else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 4'b1011; in_b = 4'b0110; in_signed = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (ir_z !== 1'b0 || ir_n !== 1'b0 || ov_z !== 1'b0 || ov_n !== 1'b0 ||
          bz_z !== 1'b0 || bz_n !== 1'b0 || ol_z !== 1'b0 || ol_n !== 1'b0 ||
          or_z !== 4'b0 || oi_z !== 3'b0 || or_n !== 4'b0 || oi_n !== 3'b0) begin
        fails++;
        $display("FAIL reset_state: ir=%b%b ov=%b%b busy=%b%b last=%b%b row=%h/%h idx=%0d/%0d, required all 0",
                 ir_z, ir_n, ov_z, ov_n, bz_z, bz_n, ol_z, ol_n, or_z, or_n, oi_z, oi_n);
      end else passes++;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (ir_z !== 1'b1 || ir_n !== 1'b1 || ov_z !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b%b out_valid=%b, required 11 0", ir_z, ir_n, ov_z);
    end else passes++;
    step();
  endtask

  task automatic test_signed();
    sel = 1'b0;
    accept(4'b1011, 4'b0110, 1'b1, 0);
    collect(0);
    check_product("signed_m5x6", 5, 40'h08132337C9, 8'd226);
    accept(4'b1111, 4'b1111, 1'b1, 0);
    collect(0);
    check_product("signed_m1xm1", 5, 40'h07172738C9, 8'd1);
    sel = 1'b1;
    accept(4'b1011, 4'b0110, 1'b1, 0);
    collect(0);
    check_product("signed_skipinst", 5, 40'h08132337C9, 8'd226);
  endtask

  task automatic test_unsigned();
    sel = 1'b1;
    accept(4'b1011, 4'b0101, 1'b0, 0);
    collect(0);
    check_product("unsigned_skip", 2, 40'h0BAB, 8'd55);
    sel = 1'b0;
    accept(4'b1011, 4'b0101, 1'b0, 0);
    collect(0);
    check_product("unsigned_noskip", 4, 40'h0B102BB0, 8'd55);
  endtask

  task automatic test_zero_multiplier();
    sel = 1'b1;
    accept(4'b1011, 4'b0000, 1'b0, 0);
    collect(0);
    check_product("zero_skip", 1, 40'h80, 8'd0);
    sel = 1'b0;
    accept(4'b1011, 4'b0000, 1'b0, 0);
    collect(0);
    check_product("zero_noskip", 4, 40'h001020B0, 8'd0);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    accept(4'b1011, 4'b0110, 1'b1, 0);
    collect(1);
    check_product("backpressure", 5, 40'h08132337C9, 8'd226);
  endtask

  task automatic test_mid_reset();
    sel = 1'b1;
    out_ready = 1'b1;
    accept(4'b1011, 4'b0110, 1'b1, 0);
    step();
    step();
    checks++;
    if (o_valid !== 1'b1 || o_idx !== 3'd2) begin
      fails++;
      $display("FAIL midrst_before: out_valid=%b idx=%0d, required 1 2", o_valid, o_idx);
    end else passes++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst_after: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               o_valid, o_busy, o_ready);
    end else passes++;
    accept(4'b0011, 4'b0101, 1'b0, 0);
    collect(0);
    check_product("midrst_restart", 2, 40'h03A3, 8'd15);
  endtask

  task automatic test_back_to_back();
    sel = 1'b1;
    accept(4'b1011, 4'b0101, 1'b0, 1);
    // Source moves on to the next operands while the first product is in flight.
    in_a = 4'b1011; in_b = 4'b0110; in_signed = 1'b1;
    collect(0);
    checks++;
    if (got_n !== 2 || got_vec !== 40'h0BAB || got_sum !== 8'd55) begin
      fails++;
      $display("FAIL b2b_first: got n=%0d %h sum=%0d, required n=2 0bab sum=55", got_n, got_vec, got_sum);
    end else passes++;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_bubble: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               o_valid, o_busy, o_ready);
    end else passes++;
    step();
    in_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_idx !== 3'd0 || o_row !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_second_accept: out_valid=%b idx=%0d row=%b, required 1 0 1000",
               o_valid, o_idx, o_row);
    end else passes++;
    collect(0);
    check_product("b2b_second", 5, 40'h08132337C9, 8'd226);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_zero_multiplier();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
